io_uart_tx: RTL and testbench
=============================

// Module: io_uart_tx
// PURPOSE
//  Memory-mapped output peripheral at the far end of the CPU's io_write/io_data strobe. The CPU writes
//  to RAM address 0xFF, which issues that strobe with no backpressure.
//  Each strobe pushes one 64-bit word into a small FIFO. A transmit FSM serialises the word's low
//  BYTES_PER_WORD bytes, LSB byte first, onto an 8N1 UART line.
//  Words that arrive while the FIFO is full are dropped and raise a sticky overflow flag.
// PARAMETERS
//  CLKS_PER_BIT    16  clk cycles per UART bit; legal range 2..65535
//  FIFO_DEPTH       8  word entries; must be a power of two, >= 2
//  BYTES_PER_WORD   1  bytes sent per word, 1..8; byte k = io_data[8k+7:8k]
// PORTS
//  clk             in   1                  single clock; all logic on posedge
//  rst             in   1                  synchronous, active-high reset
//  io_write        in   1                  one-cycle write strobe from the CPU
//  io_data         in   64                 word, valid only when io_write=1
//  clear_overflow  in   1                  clears overflow
//  tx              out  1                  UART line; idle high
//  busy            out  1                  FSM not IDLE, or FIFO non-empty
//  overflow        out  1                  sticky flag: a word was dropped
//  fifo_count      out  $clog2(FIFO_DEPTH)+1  occupancy of the FIFO
// BEHAVIOUR
//  Reset: tx=1, busy=0, overflow=0, fifo_count=0, FSM=IDLE. FIFO pointers, bit counter, byte counter
//   and baud counter are all 0. Reset mid-frame aborts the frame: tx returns high on the next cycle
//   and FIFO contents are discarded.
//  Push: io_write=1 at edge N writes io_data when (count<FIFO_DEPTH) or a pop happens at the same
//   edge. Otherwise the word is dropped and overflow<=1.
//  Push and pop at the same edge leave the count unchanged.
//  Overflow set vs clear_overflow at the same edge: set wins.
//  FSM states: IDLE, START, DATA, PARITY, STOP. Every state except IDLE lasts CLKS_PER_BIT cycles,
//   timed by the baud counter 0..CLKS_PER_BIT-1.
//   IDLE: if FIFO non-empty, pop the word into a shift register, byte_idx<=0, go to START.
//    A word pushed at edge N is therefore popped at edge N+1, and tx=0 is visible from edge N+1.
//   START: tx=0. Then DATA with bit_idx=0.
//   DATA: tx=current byte[bit_idx], LSB first. After bit 7 go to PARITY if enabled, else STOP.
//   PARITY: tx = even parity (XOR) of the current byte.
//   STOP: tx=1. Then:
//    - if byte_idx<BYTES_PER_WORD-1: byte_idx++ and go to START (back-to-back, no idle gap);
//    - else, if FIFO non-empty: pop and go to START directly;
//    - else: go to IDLE.
//  Frame length: 10 bits (11 with parity) per byte. Bytes beyond BYTES_PER_WORD are ignored.
//  tx is driven from a register (glitch-free). The FSM never stalls the push side.
//  Pointers wrap modulo FIFO_DEPTH. Full and empty are distinguished via fifo_count.
// CONFIGURATION
//  IO_UART_PARITY_EN defined: the PARITY state is inserted after DATA; even parity; 8E1 framing.
//  IO_UART_PARITY_EN undefined: the PARITY state and its logic are absent; 8N1 framing.
// STRUCTURE
//  Package io_uart_pkg:
//   - FSM state enum: IDLE, START, DATA, PARITY, STOP;
//   - UART_DATA_BITS=8;
//   - IO_ADDR=8'hFF, documenting the CPU address that produces the strobe.
//  Sub-module io_sync_fifo (params WIDTH, DEPTH):
//   - push, pop, wdata, rdata, count;
//   - rdata shows the head combinationally;
//   - pop when empty and push when full are ignored.
//  The top level holds the FSM, the counters, the shift register and the overflow logic.
// TESTING (bench: CLKS_PER_BIT=4, FIFO_DEPTH=4)
//  1 Reset: hold rst for 3 cycles -> tx=1, busy=0, overflow=0, fifo_count=0.
//  2 Single write, BYTES_PER_WORD=1, io_data=64'h41 -> the line reads:
//     - start 0;
//     - data bits 1,0,0,0,0,0,1,0, each held 4 clocks;
//     - stop 1.
//    busy drops 1 cycle after the stop bit ends. With IO_UART_PARITY_EN: parity bit 0 before stop.
//  3 BYTES_PER_WORD=2, io_data=64'h1234 -> frame 0x34 then frame 0x12, with no idle gap between them.
//  4 Six io_write strobes in 6 consecutive cycles while idle -> first word popped at once, 4 buffered,
//    1 dropped; overflow=1; 5 frames transmitted in order.
//  5 overflow=1 and clear_overflow asserted together with a dropped write -> overflow stays 1.
//    Then clear_overflow alone -> overflow=0.
//  6 Assert rst midway through the DATA state of a frame -> next cycle tx=1, fifo_count=0, busy=0.
//    Then a fresh write transmits correctly.

Source files
------------

// File: rtl/io_uart_pkg.sv
// rtl/io_uart_pkg.sv - shared types and constants for the io_uart_tx peripheral
//
// Purpose:
//   FSM state encoding, UART framing constants and the CPU address that
//   produces the io_write strobe. Imported by io_uart_tx.
//   The PARITY state value always exists; it is only reachable when
//   IO_UART_PARITY_EN is defined.

package io_uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  localparam int UART_DATA_BITS = 8;

  // RAM address whose write is decoded by the CPU into io_write/io_data.
  localparam logic [7:0] IO_ADDR = 8'hFF;

  // Even parity: the parity bit makes the total number of ones even.
  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/io_sync_fifo.sv
// rtl/io_sync_fifo.sv - single-clock word FIFO with combinational head
//
// Purpose:
//   Small synchronous FIFO. The head entry is visible on rdata without a
//   read latency so the consumer can pop and capture in the same edge.
//   Pop when empty is ignored. Push when full is ignored unless a pop
//   happens at the same edge, which frees the slot being written.
//   Full and empty are told apart by count, not by pointer comparison.
//
// Parameters:
//   WIDTH  entry width in bits
//   DEPTH  number of entries; power of two, >= 2
//
// Ports:
//   clk    clock, posedge
//   rst    synchronous active-high reset; empties the FIFO
//   push   write wdata at this edge
//   pop    drop the head entry at this edge
//   wdata  entry to write
//   rdata  current head entry (undefined content when count == 0)
//   count  occupancy, 0..DEPTH

module io_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count < FULL_CNT) || do_pop);
  assign rdata   = mem[rd_ptr];

  // Storage carries no reset; contents are meaningless until counted in.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/io_uart_tx.sv
// rtl/io_uart_tx.sv - CPU io_write strobe to buffered 8N1/8E1 UART transmitter
//
// Purpose:
//   Each io_write strobe pushes one word into a FIFO; words arriving while
//   the FIFO is full (and not being popped) are dropped and set a sticky
//   overflow flag. A transmit FSM sends the low BYTES_PER_WORD bytes of
//   each word, lowest byte first, LSB first within a byte, one start bit,
//   eight data bits, optional even parity, one stop bit.
//
// Configuration:
//   IO_UART_PARITY_EN  when defined, an even parity bit follows the data
//                      bits (8E1); otherwise frames are 8N1.
//
// Parameters:
//   CLKS_PER_BIT    clk cycles per UART bit, 2..65535
//   FIFO_DEPTH      word entries, power of two, >= 2
//   BYTES_PER_WORD  bytes sent per word, 1..8
//
// Ports:
//   clk             clock, posedge
//   rst             synchronous active-high reset; aborts any frame
//   io_write        one-cycle write strobe, no backpressure
//   io_data         64-bit word, valid with io_write
//   clear_overflow  clears overflow (a simultaneous drop wins)
//   tx              registered UART line, idle high
//   busy            FSM not idle or FIFO non-empty
//   overflow        sticky: a word was dropped
//   fifo_count      FIFO occupancy

module io_uart_tx
  import io_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT   = 16,
  parameter int FIFO_DEPTH     = 8,
  parameter int BYTES_PER_WORD = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        io_write,
  input  logic [63:0]                 io_data,
  input  logic                        clear_overflow,
  output logic                        tx,
  output logic                        busy,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int WW = UART_DATA_BITS * BYTES_PER_WORD;

  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    BIT_LAST  = 3'(UART_DATA_BITS - 1);
  localparam logic [2:0]    BYTE_LAST = 3'(BYTES_PER_WORD - 1);

  uart_state_t   state;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [2:0]    bit_nxt;
  logic [2:0]    byte_idx;
  logic [WW-1:0] shift_reg;
  logic [7:0]    cur_byte;

  logic [WW-1:0] fifo_rdata;
  logic          fifo_pop;
  logic          fifo_empty;
  logic          fifo_accept;
  logic          baud_done;
  logic          last_byte;

  // Only the low BYTES_PER_WORD bytes are stored; the rest are discarded.
  logic          unused_data;
  assign unused_data = ^io_data;

  io_sync_fifo #(
    .WIDTH (WW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (io_write),
    .pop   (fifo_pop),
    .wdata (io_data[WW-1:0]),
    .rdata (fifo_rdata),
    .count (fifo_count)
  );

  assign fifo_empty = (fifo_count == '0);
  assign baud_done  = (baud_cnt == BAUD_LAST);
  assign last_byte  = (byte_idx == BYTE_LAST);
  assign bit_nxt    = bit_idx + 3'd1;

  // The byte on the wire is always the bottom of the shift register;
  // moving to the next byte shifts the word down by eight.
  assign cur_byte   = shift_reg[7:0];

  // The FSM takes a word either from IDLE or straight out of the last
  // stop bit, so consecutive words go out without an idle gap.
  assign fifo_pop = !fifo_empty &&
                    ((state == IDLE) || ((state == STOP) && baud_done && last_byte));

  // A pop at the same edge frees a slot, so a full FIFO can still accept.
  assign fifo_accept = (fifo_count < FULL_CNT) || fifo_pop;

  assign busy = (state != IDLE) || !fifo_empty;

  // tx is assigned on each state entry so it comes straight from a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      byte_idx  <= '0;
      shift_reg <= '0;
      tx        <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          tx       <= 1'b1;
          if (!fifo_empty) begin
            shift_reg <= fifo_rdata;
            byte_idx  <= '0;
            state     <= START;
            tx        <= 1'b0;
          end
        end

        START: begin
          if (baud_done) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= DATA;
            tx       <= cur_byte[0];
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        DATA: begin
          if (baud_done) begin
            baud_cnt <= '0;
            if (bit_idx == BIT_LAST) begin
`ifdef IO_UART_PARITY_EN
              state <= PARITY;
              tx    <= even_parity(cur_byte);
`else
              state <= STOP;
              tx    <= 1'b1;
`endif
            end else begin
              bit_idx <= bit_nxt;
              tx      <= cur_byte[bit_nxt];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

`ifdef IO_UART_PARITY_EN
        PARITY: begin
          if (baud_done) begin
            baud_cnt <= '0;
            state    <= STOP;
            tx       <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`endif

        STOP: begin
          if (baud_done) begin
            baud_cnt <= '0;
            if (!last_byte) begin
              byte_idx  <= byte_idx + 3'd1;
              shift_reg <= shift_reg >> UART_DATA_BITS;
              state     <= START;
              tx        <= 1'b0;
            end else if (!fifo_empty) begin
              shift_reg <= fifo_rdata;
              byte_idx  <= '0;
              state     <= START;
              tx        <= 1'b0;
            end else begin
              state <= IDLE;
              tx    <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        default: begin
          state    <= IDLE;
          baud_cnt <= '0;
          tx       <= 1'b1;
        end
      endcase
    end
  end

  // A drop at the same edge as clear_overflow keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (io_write && !fifo_accept) begin
      overflow <= 1'b1;
    end else if (clear_overflow) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_io_uart_tx.sv
// tb/tb_io_uart_tx.sv - scoreboard bench for io_uart_tx (1- and 2-byte words)
`timescale 1ns/1ps

module tb_io_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef IO_UART_PARITY_EN
  localparam int BITS  = 11;
`else
  localparam int BITS  = 10;
`endif
  localparam int FRAME = CPB * BITS;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0, wr0, clr0, tx0, busy0, ovf0;
  logic [63:0] data0;
  logic [2:0]  cnt0;
  logic        rst1, wr1, clr1, tx1, busy1, ovf1;
  logic [63:0] data1;
  logic [2:0]  cnt1;

  io_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .BYTES_PER_WORD(1)) dut0 (
    .clk(clk), .rst(rst0), .io_write(wr0), .io_data(data0), .clear_overflow(clr0),
    .tx(tx0), .busy(busy0), .overflow(ovf0), .fifo_count(cnt0)
  );

  io_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .BYTES_PER_WORD(2)) dut1 (
    .clk(clk), .rst(rst1), .io_write(wr1), .io_data(data1), .clear_overflow(clr1),
    .tx(tx1), .busy(busy1), .overflow(ovf1), .fifo_count(cnt1)
  );

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];
  int skip0 = 0;
  int skip1 = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endfunction

  function automatic logic line(input int ch);
    return (ch == 0) ? tx0 : tx1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Decodes frames off one tx line, sampling mid-bit on negedges, and
  // scores each byte against the head of that DUT's expectation queue.
  task automatic mon(input int ch);
    logic [7:0] b;
    logic       s;
    logic [7:0] e;
`ifdef IO_UART_PARITY_EN
    logic       p;
`endif
    forever begin
      @(negedge clk);
      if (line(ch) === 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = line(ch);
        end
`ifdef IO_UART_PARITY_EN
        repeat (CPB) @(negedge clk);
        p = line(ch);
`endif
        repeat (CPB) @(negedge clk);
        s = line(ch);
        if (ch == 0 && skip0 > 0) begin
          skip0--;
        end else if (ch == 1 && skip1 > 0) begin
          skip1--;
        end else if ((ch == 0) ? (exp_q0.size() == 0) : (exp_q1.size() == 0)) begin
          total++;
          bad++;
          $display("FAIL unexpected_frame_ch%0d: got %02h want none", ch, b);
        end else begin
          e = (ch == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
          chk($sformatf("byte_ch%0d", ch), b, e);
          chk($sformatf("stop_ch%0d", ch), s, 1);
`ifdef IO_UART_PARITY_EN
          chk($sformatf("parity_ch%0d", ch), p, ^e);
`endif
        end
      end
    end
  endtask

  task automatic drain(input int ch);
    int n = 0;
    while (n < 3000 && ((ch == 0) ? (exp_q0.size() != 0 || busy0)
                                  : (exp_q1.size() != 0 || busy1))) begin
      step();
      n++;
    end
    chk($sformatf("drain_ch%0d_in_time", ch), (n < 3000), 1);
  endtask

  initial begin
    fork
      mon(0);
      mon(1);
    join_none
  end

  logic [7:0] w4 [6] = '{8'h01, 8'h80, 8'hA5, 8'h5A, 8'hFF, 8'h77};

  initial begin
    rst0 = 1; wr0 = 0; clr0 = 0; data0 = '0;
    rst1 = 1; wr1 = 0; clr1 = 0; data1 = '0;

    // 1: reset
    repeat (3) step();
    chk("rst_tx0", tx0, 1);     chk("rst_busy0", busy0, 0);
    chk("rst_ovf0", ovf0, 0);   chk("rst_cnt0", cnt0, 0);
    chk("rst_tx1", tx1, 1);     chk("rst_busy1", busy1, 0);
    chk("rst_ovf1", ovf1, 0);   chk("rst_cnt1", cnt1, 0);
    rst0 = 0; rst1 = 0;
    step();

    // 2: single byte 0x41; upper bytes must be ignored
    wr0 = 1; data0 = 64'hA5A5_0000_0000_0041; exp_q0.push_back(8'h41);
    step();
    wr0 = 0;
    chk("t2_tx_before_pop", tx0, 1);
    chk("t2_cnt_pushed", cnt0, 1);
    chk("t2_busy_set", busy0, 1);
    step();
    chk("t2_start_bit", tx0, 0);
    chk("t2_cnt_popped", cnt0, 0);
    repeat (FRAME - 1) step();
    chk("t2_busy_in_stop", busy0, 1);
    step();
    chk("t2_busy_drop", busy0, 0);
    chk("t2_tx_idle", tx0, 1);

    // 3: two-byte word, back-to-back frames 0x34 then 0x12
    wr1 = 1; data1 = 64'hFFFF_FFFF_FFFF_1234;
    exp_q1.push_back(8'h34); exp_q1.push_back(8'h12);
    step();
    wr1 = 0;
    step();
    chk("t3_start_bit", tx1, 0);
    repeat (2 * FRAME - 1) step();
    chk("t3_busy_no_gap", busy1, 1);
    step();
    chk("t3_busy_drop", busy1, 0);

    // 4: six consecutive strobes while idle; sixth is dropped
    for (int i = 0; i < 6; i++) begin
      wr0 = 1; data0 = {8'(i), 48'h0, w4[i]};
      if (i < 5) exp_q0.push_back(w4[i]);
      step();
    end
    wr0 = 0;
    chk("t4_cnt_full", cnt0, 4);
    chk("t4_overflow", ovf0, 1);

    // 5: drop and clear at the same edge -> set wins; then clear alone
    wr0 = 1; clr0 = 1; data0 = 64'h99;
    step();
    wr0 = 0;
    chk("t5_set_wins", ovf0, 1);
    chk("t5_cnt_still_full", cnt0, 4);
    step();
    clr0 = 0;
    chk("t5_cleared", ovf0, 0);
    drain(0);

    // 6: reset in the middle of DATA discards the frame and the FIFO
    wr0 = 1; data0 = 64'hC3; skip0 = 1;
    step();
    data0 = 64'h3C;
    step();
    wr0 = 0;
    repeat (14) step();
    chk("t6_cnt_before_rst", cnt0, 1);
    rst0 = 1;
    step();
    rst0 = 0;
    chk("t6_tx_high", tx0, 1);
    chk("t6_cnt_zero", cnt0, 0);
    chk("t6_busy_low", busy0, 0);
    repeat (60) step();
    wr0 = 1; data0 = 64'h96; exp_q0.push_back(8'h96);
    step();
    wr0 = 0;
    drain(0);
    drain(1);
    repeat (10) step();

    chk("end_q0_empty", exp_q0.size(), 0);
    chk("end_q1_empty", exp_q1.size(), 0);
    chk("end_skip0_used", skip0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
